// File: rtl/reg_file_param_if.sv
// reg_file_param_if -- decode/writeback bus of the register file.
//   Write port  : wr_en, wr_id, wr_data; decoded one-hot select on wordline.
//   Read ports  : rd_id1/rd_id2 -> rd_data1/rd_data2, rd_busy1/rd_busy2.
//   Scoreboard  : busy_set, busy_id (mark pending); busy_vec (full state).
// master = decode/writeback side, slave = register file.
interface reg_file_param_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_id;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_REGS-1:0]   wordline;
  logic [ADDR_WIDTH-1:0] rd_id1;
  logic [ADDR_WIDTH-1:0] rd_id2;
  logic [DATA_WIDTH-1:0] rd_data1;
  logic [DATA_WIDTH-1:0] rd_data2;
  logic                  busy_set;
  logic [ADDR_WIDTH-1:0] busy_id;
  logic                  rd_busy1;
  logic                  rd_busy2;
  logic [NUM_REGS-1:0]   busy_vec;

  modport master (
    output wr_en, wr_id, wr_data, rd_id1, rd_id2, busy_set, busy_id,
    input  wordline, rd_data1, rd_data2, rd_busy1, rd_busy2, busy_vec
  );

  modport slave (
    input  wr_en, wr_id, wr_data, rd_id1, rd_id2, busy_set, busy_id,
    output wordline, rd_data1, rd_data2, rd_busy1, rd_busy2, busy_vec
  );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param -- 2**ADDR_WIDTH x DATA_WIDTH register file with one-hot
// write decoder, two asynchronous read ports and a pending-write scoreboard.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears registers and scoreboard)
//   bus  : reg_file_param_if.slave (write, read, scoreboard signals)
// Parameters: DATA_WIDTH, ADDR_WIDTH, ZERO_REG (r0 hardwired to zero, never busy).
// Optional macro REGFILE_BYPASS_EN: forwards same-cycle write data to the read
// ports and shows a same-cycle clear on rd_busyN (busy_vec stays registered).
module reg_file_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 1
) (
  input logic             clk,
  input logic             rst,
  reg_file_param_if.slave bus
);
  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   wordline;
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  zero1;
  logic                  zero2;

  always_comb begin
    wordline = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wordline[i] = bus.wr_en && (bus.wr_id == ADDR_WIDTH'(i));
    end
    if (ZERO_REG != 0) wordline[0] = 1'b0;
  end

  // Set has priority over clear: the newly issued instruction owns the register.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.busy_set && (bus.busy_id == ADDR_WIDTH'(i))) begin
        busy_d[i] = 1'b1;
      end else if (bus.wr_en && (bus.wr_id == ADDR_WIDTH'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wordline[i]) regs[i] <= bus.wr_data;
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    zero1 = (ZERO_REG != 0) && (bus.rd_id1 == '0);
    zero2 = (ZERO_REG != 0) && (bus.rd_id2 == '0);

    bus.rd_data1 = zero1 ? '0 : regs[bus.rd_id1];
    bus.rd_data2 = zero2 ? '0 : regs[bus.rd_id2];
    bus.rd_busy1 = busy_q[bus.rd_id1];
    bus.rd_busy2 = busy_q[bus.rd_id2];

`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && (bus.wr_id == bus.rd_id1) && !zero1) begin
      bus.rd_data1 = bus.wr_data;
      bus.rd_busy1 = bus.busy_set && (bus.busy_id == bus.rd_id1);
    end
    if (bus.wr_en && (bus.wr_id == bus.rd_id2) && !zero2) begin
      bus.rd_data2 = bus.wr_data;
      bus.rd_busy2 = bus.busy_set && (bus.busy_id == bus.rd_id2);
    end
`endif
  end

  assign bus.wordline = wordline;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: array/arithmetic reference model updated on each
// rising edge, a per-cycle compare on the falling edge, and directed literal
// checks from the stimulus thread.
module tb_reg_file_param;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam int ZR = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  bit   check_en = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  reg_file_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(ZR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_zero(input int id);
    return (ZR != 0) && (id == 0);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int id);
    logic [DW-1:0] v;
    v = is_zero(id) ? '0 : m_regs[id];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && int'(bus.wr_id) == id && !is_zero(id)) v = bus.wr_data;
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input int id);
    logic b;
    b = m_busy[id];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && int'(bus.wr_id) == id && !is_zero(id))
      b = bus.busy_set && int'(bus.busy_id) == id;
`endif
    return b;
  endfunction

  function automatic logic [NR-1:0] exp_wordline();
    logic [NR-1:0] w;
    w = bus.wr_en ? (NR'(1) << bus.wr_id) : '0;
    if (ZR != 0) w[0] = 1'b0;
    return w;
  endfunction

  function automatic logic [NR-1:0] exp_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Reference model: applied once per rising edge from the inputs seen there.
  initial begin
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 0;
    end
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NR; i++) begin
          m_regs[i] = '0;
          m_busy[i] = 0;
        end
      end else begin
        if (bus.wr_en) begin
          if (!is_zero(int'(bus.wr_id))) m_regs[bus.wr_id] = bus.wr_data;
          m_busy[bus.wr_id] = 0;
        end
        if (bus.busy_set) m_busy[bus.busy_id] = 1;
        if (ZR != 0) m_busy[0] = 0;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        check("wordline", 32'(bus.wordline), 32'(exp_wordline()));
        check("rd_data1", 32'(bus.rd_data1), 32'(exp_data(int'(bus.rd_id1))));
        check("rd_data2", 32'(bus.rd_data2), 32'(exp_data(int'(bus.rd_id2))));
        check("rd_busy1", 32'(bus.rd_busy1), 32'(exp_busy(int'(bus.rd_id1))));
        check("rd_busy2", 32'(bus.rd_busy2), 32'(exp_busy(int'(bus.rd_id2))));
        check("busy_vec", 32'(bus.busy_vec), 32'(exp_busy_vec()));
      end
    end
  end

  task automatic idle();
    bus.wr_en = 0; bus.wr_id = '0; bus.wr_data = '0;
    bus.busy_set = 0; bus.busy_id = '0;
  endtask

  // Advance: apply the current inputs on the next edge, return just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    idle();
    bus.rd_id1 = '0;
    bus.rd_id2 = '0;
    cyc();
    cyc();
    check_en = 1;
    rst = 0;

    // Reset state sweep.
    for (int id = 0; id < NR; id++) begin
      bus.rd_id1 = AW'(id);
      @(negedge clk);
      check("reset_rd_data1", 32'(bus.rd_data1), 32'h0);
      check("reset_rd_busy1", 32'(bus.rd_busy1), 32'h0);
      cyc();
    end
    check("reset_busy_vec", 32'(bus.busy_vec), 32'h0);

    // Decoder sweep with zero data so the array stays clear.
    bus.wr_en = 1;
    for (int id = 0; id < NR; id++) begin
      bus.wr_id = AW'(id);
      @(negedge clk);
      check("wordline_sweep", 32'(bus.wordline), (id == 0) ? 32'h0 : (32'h1 << id));
      cyc();
    end
    bus.wr_id = 4'd6;
    @(negedge clk);
    check("wordline_r6", 32'(bus.wordline), 32'h0040);
    bus.wr_en = 0;
    @(negedge clk);
    check("wordline_off", 32'(bus.wordline), 32'h0);
    cyc();

    // Basic write / read.
    bus.wr_en = 1; bus.wr_id = 4'd5; bus.wr_data = 16'hBEEF;
    cyc();
    idle();
    bus.rd_id1 = 4'd5; bus.rd_id2 = 4'd5;
    @(negedge clk);
    check("r5_port1", 32'(bus.rd_data1), 32'hBEEF);
    check("r5_port2", 32'(bus.rd_data2), 32'hBEEF);
    cyc();
    bus.wr_en = 1; bus.wr_id = 4'd0; bus.wr_data = 16'h1234;
    cyc();
    idle();
    bus.rd_id1 = 4'd0;
    @(negedge clk);
    check("r0_zero", 32'(bus.rd_data1), 32'h0);
    cyc();

    // Same-cycle write and read of r3.
    bus.wr_en = 1; bus.wr_id = 4'd3; bus.wr_data = 16'h0001;
    cyc();
    bus.wr_data = 16'hA5A5; bus.rd_id1 = 4'd3;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("r3_same_cycle", 32'(bus.rd_data1), 32'hA5A5);
`else
    check("r3_same_cycle", 32'(bus.rd_data1), 32'h0001);
`endif
    cyc();
    idle();
    @(negedge clk);
    check("r3_next_cycle", 32'(bus.rd_data1), 32'hA5A5);
    cyc();

    // Scoreboard.
    bus.busy_set = 1; bus.busy_id = 4'd7;
    cyc();
    idle();
    bus.rd_id2 = 4'd7;
    @(negedge clk);
    check("busy_r7_set", 32'(bus.busy_vec), 32'h0080);
    check("rd_busy2_r7", 32'(bus.rd_busy2), 32'h1);
    bus.busy_set = 1; bus.busy_id = 4'd7;
    bus.wr_en = 1; bus.wr_id = 4'd7; bus.wr_data = 16'h7777;
    cyc();
    idle();
    @(negedge clk);
    check("busy_r7_set_wins", 32'(bus.busy_vec), 32'h0080);
    bus.wr_en = 1; bus.wr_id = 4'd7; bus.wr_data = 16'h7778;
    cyc();
    idle();
    @(negedge clk);
    check("busy_r7_clear", 32'(bus.busy_vec), 32'h0);
    bus.busy_set = 1; bus.busy_id = 4'd0;
    cyc();
    idle();
    @(negedge clk);
    check("busy_r0_never", 32'(bus.busy_vec), 32'h0);
    cyc();

    // Reset mid-operation.
    bus.wr_en = 1; bus.wr_id = 4'd9; bus.wr_data = 16'hFFFF;
    bus.busy_set = 1; bus.busy_id = 4'd2;
    cyc();
    idle();
    bus.rd_id1 = 4'd9;
    @(negedge clk);
    check("r9_written", 32'(bus.rd_data1), 32'hFFFF);
    check("busy_r2", 32'(bus.busy_vec), 32'h0004);
    rst = 1;
    bus.wr_en = 1; bus.wr_id = 4'd4; bus.wr_data = 16'h5555;
    bus.busy_set = 1; bus.busy_id = 4'd6;
    @(negedge clk);
    check("wordline_in_rst", 32'(bus.wordline), 32'h0010);
    cyc();
    rst = 0;
    idle();
    bus.rd_id1 = 4'd4; bus.rd_id2 = 4'd9;
    @(negedge clk);
    check("r4_after_rst", 32'(bus.rd_data1), 32'h0);
    check("r9_after_rst", 32'(bus.rd_data2), 32'h0);
    check("busy_after_rst", 32'(bus.busy_vec), 32'h0);
    cyc();

    // Mixed traffic against the model.
    for (int n = 0; n < 300; n++) begin
      bus.wr_en    = 1'($urandom_range(0, 1));
      bus.wr_id    = AW'($urandom_range(0, NR - 1));
      bus.wr_data  = DW'($urandom);
      bus.busy_set = 1'($urandom_range(0, 1));
      bus.busy_id  = ($urandom_range(0, 3) == 0) ? bus.wr_id : AW'($urandom_range(0, NR - 1));
      bus.rd_id1   = ($urandom_range(0, 2) == 0) ? bus.wr_id : AW'($urandom_range(0, NR - 1));
      bus.rd_id2   = AW'($urandom_range(0, NR - 1));
      cyc();
    end
    idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised register file for the pipelined WISC core: a 2^ADDR_WIDTH × DATA_WIDTH register array with an integrated, enable-gated one-hot write decoder. It has two asynchronous read ports and a per-register pending-write scoreboard that the decode stage uses for hazard detection. It sits between decode (reads, busy marking) and writeback (writes, busy clearing).

## Interface
- DATA_WIDTH, 16, register width in bits.
- ADDR_WIDTH, 4, register id width; NUM_REGS = 2**ADDR_WIDTH.
- ZERO_REG, 1, when 1: register 0 reads as zero, ignores writes, is never busy.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- wr_en  input  1  writeback write request.
- wr_id  input  ADDR_WIDTH  destination register of the write.
- wr_data  input  DATA_WIDTH  write data.
- wordline  output  NUM_REGS  decoded one-hot write select, combinational.
- rd_id1, rd_id2  input  ADDR_WIDTH  read port select.
- rd_data1, rd_data2  output  DATA_WIDTH  read data, combinational.
- busy_set  input  1  decode issues an instruction writing busy_id.
- busy_id  input  ADDR_WIDTH  register to mark pending.
- rd_busy1, rd_busy2  output  1  pending-write status of rd_id1 / rd_id2.
- busy_vec  output  NUM_REGS  full scoreboard state.

## Operation
- Write decode:
  - wordline[i] = wr_en & (wr_id == i).
  - All zeros when wr_en = 0.
  - Exactly one bit set when wr_en = 1.
  - With ZERO_REG = 1, wordline[0] is forced to 0.
- Write: on the rising edge, reg[i] <= wr_data for the single i with wordline[i] = 1. All other registers hold.
- Read:
  - rd_dataN = reg[rd_idN] combinationally.
  - With ZERO_REG = 1 and rd_idN = 0, rd_dataN = 0 regardless of the stored value.
- Scoreboard, one bit per register, busy[i]:
  - Set: busy_set & busy_id == i.
  - Clear: wr_en & wr_id == i.
  - Same register set and cleared in one cycle: set wins; busy stays 1 because the newer instruction owns the register.
  - Set with no clear: 1. Clear with no set: 0. Otherwise hold.
  - With ZERO_REG = 1, busy[0] is constant 0.
- rd_busyN = busy[rd_idN] using the registered state. A clear in the current cycle is not reflected until the next cycle, unless the bypass described under Configuration is compiled in.
- Reads and both ports referencing the same register are unrestricted.
- Scoreboard gives no over-commit protection: a second busy_set to an already busy register simply keeps it at 1.

## Timing
- Reset: on a rising edge with rst = 1:
  - All registers <= 0 and busy_vec <= 0.
  - wr_en and busy_set in that cycle are ignored.
- Reset mid-operation discards all pending state; the next cycle reads all zeros and not-busy.
- Write latency: data is visible on the read ports the cycle after the write edge.
- Scoreboard latency: a set is visible on rd_busyN / busy_vec the cycle after the busy_set edge.
- Outputs during and after reset, before any write:
  - rd_data1 = rd_data2 = 0.
  - rd_busy1 = rd_busy2 = 0.
  - busy_vec = 0.
  - wordline follows wr_en / wr_id combinationally, even while rst = 1.
- No handshakes; every request is accepted in the cycle presented.
- Id arithmetic: ids are unsigned ADDR_WIDTH. No out-of-range ids exist because NUM_REGS = 2**ADDR_WIDTH.

## Configuration
- REGFILE_BYPASS_EN, when defined:
  - Read bypass: if wr_en = 1 and wr_id == rd_idN (and not the zero register under ZERO_REG), rd_dataN = wr_data in the same cycle.
  - Busy bypass: rd_busyN = 0 in that cycle, unless busy_set & busy_id == rd_idN in the same cycle.
  - busy_vec always shows registered state.
- REGFILE_BYPASS_EN, when undefined:
  - rd_dataN shows the old stored value during a same-cycle write.
  - rd_busyN shows the registered busy bit.
  - Decode must stall one extra cycle.

## Test plan
- Reset, then sweep rd_id1 over 0..15 -> rd_data1 = 0x0000 and rd_busy1 = 0 for every id; busy_vec = 0x0000.
- wr_en = 1 for each wr_id 0..15 -> wordline = 1<<wr_id, except wordline = 0x0000 for id 0 with ZERO_REG = 1. wr_en = 0 -> 0x0000.
- Write 0xBEEF to r5, then read r5 on both ports next cycle -> 0xBEEF on rd_data1 and rd_data2. Write 0x1234 to r0 -> r0 reads 0x0000 with ZERO_REG = 1; with ZERO_REG = 0, r0 reads 0x1234 the next cycle.
- Same-cycle write of 0xA5A5 to r3 with rd_id1 = 3, r3 previously 0x0001:
  - With REGFILE_BYPASS_EN: rd_data1 = 0xA5A5 in that cycle.
  - Without: rd_data1 = 0x0001, then 0xA5A5 the next cycle.
- busy_set on r7 -> busy_vec[7] = 1 the next cycle. Then assert busy_set on r7 and a write to r7 in the same cycle -> busy_vec[7] stays 1. Write r7 alone -> busy_vec[7] = 0 the next cycle. busy_set on r0 with ZERO_REG = 1 -> busy_vec[0] stays 0.
- Write 0xFFFF to r9 and mark r2 busy, then assert rst for one cycle together with wr_en (r4, 0x5555) -> r4 = 0x0000, r9 = 0x0000, busy_vec = 0x0000 after the reset edge.
